// File: rtl/rec_play_timer_pkg.sv
// Shared types and constants for the recorder/player elapsed-seconds timer.
package rec_play_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] BLANK_TIME = 6'd63;

  localparam logic MODE_REC  = 1'b0;
  localparam logic MODE_PLAY = 1'b1;

endpackage

// File: rtl/rec_play_timer_rate_tick_gen.sv
// Fractional-rate accumulator: emits a one-cycle tick each time CYCLES_PER_SEC
// units of scaled time have accumulated while enabled.
module rate_tick_gen #(
  parameter int unsigned CYCLES_PER_SEC = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       fast,
  input  logic       slow,
  input  logic [2:0] speed,
  output logic       tick
);

  localparam logic [31:0] CPS = 32'(CYCLES_PER_SEC);

  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [2:0]  sub;
  logic [2:0]  sub_next;
  logic [3:0]  inc;

  // Slow mode spreads one unit over speed+1 cycles; fast adds speed+1 per cycle.
  always_comb begin
    inc      = 4'd1;
    sub_next = sub;
    if (slow) begin
      if (sub == speed) begin
        inc      = 4'd1;
        sub_next = 3'd0;
      end else begin
        inc      = 4'd0;
        sub_next = sub + 3'd1;
      end
    end else if (fast) begin
      inc = {1'b0, speed} + 4'd1;
    end
    acc_next = acc + {28'd0, inc};
    tick     = enable && !clear && (acc_next >= CPS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc <= 32'd0;
      sub <= 3'd0;
    end else if (enable) begin
      sub <= sub_next;
      acc <= tick ? (acc_next - CPS) : acc_next;
    end
  end

endmodule

// File: rtl/rec_play_timer.sv
// Elapsed-seconds counter for record/play sessions driving the two-digit time
// display; shows the blank code whenever no session exists.
module rec_play_timer
  import rec_play_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SEC = 12000000,
  parameter int unsigned MAX_TIME       = 32,
  parameter logic [5:0]  BLANK          = BLANK_TIME
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_stop,
  input  logic       i_mode,
  input  logic       i_fast,
  input  logic       i_slow,
  input  logic [2:0] i_speed,
  input  logic [5:0] i_limit,
  output logic [5:0] o_time,
  output logic [1:0] o_state,
  output logic       o_done
);

  localparam logic [5:0] MAX_T = 6'(MAX_TIME);

  state_t     state;
  logic       mode;
  logic [5:0] sec;
  logic [5:0] end_time;
  logic [5:0] start_end;
  logic       launch;
  logic       run_en;
  logic       fast_eff;
  logic       slow_eff;
  logic       tick;

  assign start_end = (i_mode == MODE_PLAY && i_limit < MAX_T) ? i_limit : MAX_T;
  assign launch    = (state == IDLE || state == DONE) && i_start && !i_stop;
  assign run_en    = (state == RUN) && !i_pause;
  // Speed controls only matter in play mode; slow wins over fast.
  assign fast_eff  = (mode == MODE_PLAY) && i_fast && !i_slow;
  assign slow_eff  = (mode == MODE_PLAY) && i_slow;

  rate_tick_gen #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_rate (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .enable(run_en),
    .clear (launch),
    .fast  (fast_eff),
    .slow  (slow_eff),
    .speed (i_speed),
    .tick  (tick)
  );

  // Outputs are loaded with the same next values as the state registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      sec      <= 6'd0;
      mode     <= MODE_REC;
      end_time <= 6'd0;
      o_time   <= BLANK;
      o_state  <= IDLE;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (i_stop) begin
            state   <= IDLE;
            o_state <= IDLE;
            o_time  <= BLANK;
          end else if (i_start) begin
            mode     <= i_mode;
            end_time <= start_end;
            sec      <= 6'd0;
            o_time   <= 6'd0;
            if (start_end == 6'd0) begin
              state   <= DONE;
              o_state <= DONE;
              o_done  <= 1'b1;
            end else begin
              state   <= RUN;
              o_state <= RUN;
            end
          end
        end
        RUN: begin
          if (i_stop) begin
            state   <= IDLE;
            o_state <= IDLE;
            o_time  <= BLANK;
          end else if (i_pause) begin
            state   <= PAUSE;
            o_state <= PAUSE;
          end else if (tick) begin
            sec    <= sec + 6'd1;
            o_time <= sec + 6'd1;
            if (sec + 6'd1 == end_time) begin
              state   <= DONE;
              o_state <= DONE;
              o_done  <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (i_stop) begin
            state   <= IDLE;
            o_state <= IDLE;
            o_time  <= BLANK;
          end else if (i_start) begin
            state   <= RUN;
            o_state <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rec_play_timer.sv
// Scoreboard bench for rec_play_timer: a cycle model pushes expected outputs
// as each stimulus cycle is driven, and they are popped after the clock edge.
module tb_rec_play_timer;

  localparam int CPS = 10;
  localparam int MT  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic       fast = 1'b0;
  logic       slow = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [5:0] limit = 6'd0;
  logic [5:0] time_v;
  logic [1:0] state_v;
  logic       done_v;

  rec_play_timer #(
    .CYCLES_PER_SEC(CPS),
    .MAX_TIME      (MT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_pause(pause),
    .i_stop (stop),
    .i_mode (mode),
    .i_fast (fast),
    .i_slow (slow),
    .i_speed(speed),
    .i_limit(limit),
    .o_time (time_v),
    .o_state(state_v),
    .o_done (done_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] t;
    logic [1:0] s;
    logic       d;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  int m_state = 0;
  int m_sec   = 0;
  int m_acc   = 0;
  int m_sub   = 0;
  int m_mode  = 0;
  int m_end   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs about to be sampled.
  task automatic model();
    exp_t e;
    int   inc;
    e.d = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_sec = 0; m_acc = 0; m_sub = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (stop) m_state = 0;
      else if (start) begin
        m_mode = int'(mode);
        m_end  = mode ? ((int'(limit) > MT) ? MT : int'(limit)) : MT;
        m_sec = 0; m_acc = 0; m_sub = 0;
        if (m_end == 0) begin m_state = 3; e.d = 1'b1; end
        else m_state = 1;
      end
    end else if (m_state == 2) begin
      if (stop) m_state = 0;
      else if (start) m_state = 1;
    end else begin
      if (stop) m_state = 0;
      else if (pause) m_state = 2;
      else begin
        if (m_mode == 1 && slow) begin
          inc   = (m_sub == int'(speed)) ? 1 : 0;
          m_sub = (m_sub == int'(speed)) ? 0 : (m_sub + 1) % 8;
        end else if (m_mode == 1 && fast) inc = int'(speed) + 1;
        else inc = 1;
        m_acc += inc;
        if (m_acc >= CPS) begin
          m_acc -= CPS;
          m_sec++;
          if (m_sec == m_end) begin m_state = 3; e.d = 1'b1; end
        end
      end
    end
    e.s = 2'(m_state);
    e.t = (m_state == 0) ? 6'd63 : 6'(m_sec);
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic st, input logic pa, input logic sp);
    exp_t e;
    start = st; pause = pa; stop = sp;
    model();
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("time", 32'(time_v), 32'(e.t));
    check("state", 32'(state_v), 32'(e.s));
    check("done", 32'(done_v), 32'(e.d));
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset and first record seconds
    rst_n = 1'b0;
    run(2);
    check("rst_time", 32'(time_v), 32'd63);
    check("rst_state", 32'(state_v), 32'd0);
    rst_n = 1'b1;
    run(1);
    mode = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    run(10);
    check("rec_1s", 32'(time_v), 32'd1);
    run(10);
    check("rec_2s", 32'(time_v), 32'd2);
    run(19);
    check("rec_pre_end", 32'(state_v), 32'd1);
    run(1);
    check("rec_done_state", 32'(state_v), 32'd3);
    check("rec_done_pulse", 32'(done_v), 32'd1);
    run(1);
    check("rec_done_clr", 32'(done_v), 32'd0);
    check("rec_hold", 32'(time_v), 32'd4);
    run(3);
    cyc(1'b0, 1'b0, 1'b1);
    check("rec_stop", 32'(time_v), 32'd63);

    // pause freezes the accumulator
    cyc(1'b1, 1'b0, 1'b0);
    run(15);
    check("pause_pre", 32'(time_v), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    run(50);
    check("pause_hold", 32'(time_v), 32'd1);
    check("pause_state", 32'(state_v), 32'd2);
    cyc(1'b1, 1'b0, 1'b0);
    run(4);
    check("resume_pre", 32'(time_v), 32'd1);
    run(1);
    check("resume_2s", 32'(time_v), 32'd2);
    cyc(1'b0, 1'b0, 1'b1);

    // play fast x4 to limit 2
    mode = 1'b1; limit = 6'd2; fast = 1'b1; speed = 3'd3;
    cyc(1'b1, 1'b0, 1'b0);
    run(2);
    check("fast_c2", 32'(time_v), 32'd0);
    run(1);
    check("fast_c3", 32'(time_v), 32'd1);
    run(2);
    check("fast_end_time", 32'(time_v), 32'd2);
    check("fast_end_done", 32'(done_v), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);

    // play slow /2 to limit 1, then zero-length session from DONE
    limit = 6'd1; fast = 1'b0; slow = 1'b1; speed = 3'd1;
    cyc(1'b1, 1'b0, 1'b0);
    run(19);
    check("slow_c19", 32'(time_v), 32'd0);
    run(1);
    check("slow_end", 32'(state_v), 32'd3);
    limit = 6'd0;
    cyc(1'b1, 1'b0, 1'b0);
    check("zero_state", 32'(state_v), 32'd3);
    check("zero_done", 32'(done_v), 32'd1);
    check("zero_time", 32'(time_v), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);

    // limit clamped to MAX_TIME, live speed changes
    limit = 6'd50; slow = 1'b0; fast = 1'b1; speed = 3'd1;
    cyc(1'b1, 1'b0, 1'b0);
    run(6);
    speed = 3'd0;
    run(10);
    slow = 1'b1; speed = 3'd2;
    run(30);
    slow = 1'b0; fast = 1'b0;
    run(40);
    check("clamp_state", 32'(state_v), 32'd3);
    check("clamp_time", 32'(time_v), 32'd4);
    cyc(1'b0, 1'b0, 1'b1);
    mode = 1'b0;

    // stop wins over start in RUN
    cyc(1'b1, 1'b0, 1'b0);
    run(3);
    cyc(1'b1, 1'b0, 1'b1);
    check("stopstart_time", 32'(time_v), 32'd63);
    check("stopstart_state", 32'(state_v), 32'd0);

    // stop on the final tick suppresses done
    cyc(1'b1, 1'b0, 1'b0);
    run(39);
    cyc(1'b0, 1'b0, 1'b1);
    check("stopend_state", 32'(state_v), 32'd0);
    check("stopend_done", 32'(done_v), 32'd0);
    run(2);

    // reset mid-run aborts silently
    cyc(1'b1, 1'b0, 1'b0);
    run(12);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    check("midrst_time", 32'(time_v), 32'd63);
    check("midrst_done", 32'(done_v), 32'd0);
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
